// File: rtl/display_pkg.sv
// Shared layout for the note window and display stage.
// Entries are {note, start_beat, duration}, duration in the LSBs.
package display_pkg;

    function automatic int state_bits(int note_bits, int beat_bits);
        return note_bits + 2 * beat_bits;
    endfunction

    function automatic int state_size(int beats, int simul);
        return 2 * beats * simul;
    endfunction

    function automatic int window_len(int beats, int beat_dur);
        return beats * beat_dur;
    endfunction

    function automatic int window_bits(int beat_bits);
        return beat_bits + 2;
    endfunction

    function automatic int dur_lsb();
        return 0;
    endfunction

    function automatic int start_lsb(int beat_bits);
        return beat_bits;
    endfunction

    function automatic int note_lsb(int beat_bits);
        return 2 * beat_bits;
    endfunction

endpackage

// File: rtl/display_note_window_if.sv
// Note event handshake into the window.
// The producer drives the note; the window answers with ready.
interface display_note_window_if #(
    parameter int NOTE_BITS = 6,
    parameter int BEAT_BITS = 16
);
    logic                 note_in_valid;
    logic [NOTE_BITS-1:0] note_in;
    logic [BEAT_BITS-1:0] note_in_duration;
    logic                 note_in_ready;

    modport master (
        output note_in_valid, note_in, note_in_duration,
        input  note_in_ready
    );

    modport slave (
        input  note_in_valid, note_in, note_in_duration,
        output note_in_ready
    );
endinterface

// File: rtl/display_note_window_first_free_slot.sv
// Priority encoder: lowest set bit of the free mask.
// Also reports whether any bit is set.
module first_free_slot #(
    parameter  int N  = 16,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  free,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (free[i]) idx = IW'(i);
        end
    end

    assign any = |free;
endmodule

// File: rtl/display_note_window.sv
// Sliding window of on-screen notes with per-frame snapshot.
// Stamps, stores and evicts notes; publishes on frame_start.
module display_note_window
    import display_pkg::*;
#(
    parameter  int DISPLAYED_BEATS    = 4,
    parameter  int SIMULTANEOUS_NOTES = 2,
    parameter  int BEAT_DURATION      = 48,
    parameter  int BEAT_BITS          = 16,
    parameter  int NOTE_BITS          = 6,
    localparam int NSB = state_bits(NOTE_BITS, BEAT_BITS),
    localparam int NSS = state_size(DISPLAYED_BEATS, SIMULTANEOUS_NOTES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reset_player,
    input  logic                 play,
    input  logic                 song_done,
    input  logic                 beat_tick,
    input  logic                 frame_start,
    display_note_window_if.slave note_bus,
    output logic [NSB-1:0]       notes [NSS],
    output logic                 valid,
    output logic [BEAT_BITS-1:0] current_beat
);
    localparam int WB = window_bits(BEAT_BITS);
    localparam int IW = (NSS > 1) ? $clog2(NSS) : 1;
    localparam int DL = dur_lsb();
    localparam int SL = start_lsb(BEAT_BITS);
    localparam logic [WB-1:0] WIN =
        WB'(window_len(DISPLAYED_BEATS, BEAT_DURATION));

    logic [NSB-1:0] slots   [NSS];
    logic [NSB-1:0] slots_n [NSS];
    logic [NSS-1:0] free;
    logic [IW-1:0]  idx;
    logic           any_free;
    logic           take;
    logic           advance;
    logic [WB-1:0]  lim;

    always_comb begin
        for (int i = 0; i < NSS; i++) begin
            free[i] = ~|slots[i][DL +: BEAT_BITS];
        end
    end

    first_free_slot #(.N(NSS)) u_ffs (
        .free (free),
        .idx  (idx),
        .any  (any_free)
    );

    // rst gates ready so it reads 0 while held in reset
    assign note_bus.note_in_ready = rst & any_free & ~reset_player;

    assign take = note_bus.note_in_valid & note_bus.note_in_ready
                & (|note_bus.note_in_duration);

    assign advance = beat_tick & play & ~song_done & ~&current_beat;

    // target comes from pre-eviction emptiness, so no collision
    always_comb begin
        slots_n = slots;
        lim     = '0;
        for (int i = 0; i < NSS; i++) begin
            lim = WB'(slots[i][SL +: BEAT_BITS])
                + WB'(slots[i][DL +: BEAT_BITS]) + WIN;
            if (!free[i] && lim <= WB'(current_beat)) begin
                slots_n[i] = '0;
            end
        end
        if (take) begin
            slots_n[idx] = {note_bus.note_in, current_beat,
                            note_bus.note_in_duration};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slots        <= '{default: '0};
            notes        <= '{default: '0};
            valid        <= 1'b0;
            current_beat <= '0;
        end else if (reset_player) begin
            slots        <= '{default: '0};
            notes        <= '{default: '0};
            valid        <= 1'b0;
            current_beat <= '0;
        end else begin
            slots <= slots_n;
            if (frame_start) begin
                notes <= slots;
                valid <= 1'b1;
            end
            if (advance) current_beat <= current_beat + 1'b1;
        end
    end
endmodule

// File: tb/tb_display_note_window.sv
// Randomised and directed bench for display_note_window.
// A slot-list model predicts every output each cycle.
module tb_display_note_window;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic reset_player = 1'b0;
    logic play = 1'b0;
    logic song_done = 1'b0;
    logic beat_tick = 1'b0;
    logic frame_start = 1'b0;
    logic [37:0] notes [16];
    logic valid;
    logic [15:0] current_beat;

    int compared = 0;
    int mismatched = 0;

    display_note_window_if #(.NOTE_BITS(6), .BEAT_BITS(16)) bus ();

    display_note_window #(
        .DISPLAYED_BEATS(4), .SIMULTANEOUS_NOTES(2),
        .BEAT_DURATION(48), .BEAT_BITS(16), .NOTE_BITS(6)
    ) dut (
        .clk(clk), .rst(rst), .reset_player(reset_player),
        .play(play), .song_done(song_done), .beat_tick(beat_tick),
        .frame_start(frame_start), .note_bus(bus),
        .notes(notes), .valid(valid), .current_beat(current_beat)
    );

    always #5 clk = ~clk;

    // model: live notes, published copy, song position
    int m_note[16], m_start[16], m_dur[16];
    int p_note[16], p_start[16], p_dur[16];
    bit m_valid = 0;
    int m_beat = 0;

    function automatic logic [37:0] ent(int n, int s, int d);
        return {6'(n), 16'(s), 16'(d)};
    endfunction

    function automatic bit exp_ready();
        bit any = 0;
        for (int i = 0; i < 16; i++) if (m_dur[i] == 0) any = 1;
        return rst && any && !reset_player;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin : model
        int n_note[16], n_start[16], n_dur[16];
        int tgt;
        bit acc;
        if (!rst || reset_player) begin
            for (int i = 0; i < 16; i++) begin
                m_note[i] <= 0; m_start[i] <= 0; m_dur[i] <= 0;
                p_note[i] <= 0; p_start[i] <= 0; p_dur[i] <= 0;
            end
            m_valid <= 0;
            m_beat  <= 0;
        end else begin
            acc = exp_ready() && bus.note_in_valid
                && bus.note_in_duration != 0;
            n_note = m_note; n_start = m_start; n_dur = m_dur;
            for (int i = 0; i < 16; i++) begin
                if (m_dur[i] != 0 && m_start[i] + m_dur[i] + 192 <= m_beat) begin
                    n_note[i] = 0; n_start[i] = 0; n_dur[i] = 0;
                end
            end
            tgt = -1;
            for (int i = 0; i < 16; i++)
                if (tgt < 0 && m_dur[i] == 0) tgt = i;
            if (acc && tgt >= 0) begin
                n_note[tgt]  = int'(bus.note_in);
                n_start[tgt] = m_beat;
                n_dur[tgt]   = int'(bus.note_in_duration);
            end
            m_note <= n_note; m_start <= n_start; m_dur <= n_dur;
            if (frame_start) begin
                p_note <= m_note; p_start <= m_start; p_dur <= m_dur;
                m_valid <= 1;
            end
            if (beat_tick && play && !song_done && m_beat < 65535)
                m_beat <= m_beat + 1;
        end
    end

    always @(negedge clk) begin
        chk("ready", 64'(bus.note_in_ready), 64'(exp_ready()));
        chk("valid", 64'(valid), 64'(m_valid));
        chk("current_beat", 64'(current_beat), 64'(m_beat));
        for (int i = 0; i < 16; i++)
            chk($sformatf("notes[%0d]", i), 64'(notes[i]),
                64'(ent(p_note[i], p_start[i], p_dur[i])));
    end

    task automatic step(input bit bt, input bit fs, input bit v,
                        input int n, input int d, input bit rp);
        beat_tick = bt; frame_start = fs; reset_player = rp;
        bus.note_in_valid = v;
        bus.note_in = 6'(n);
        bus.note_in_duration = 16'(d);
        @(posedge clk); #1;
        beat_tick = 0; frame_start = 0; reset_player = 0;
        bus.note_in_valid = 0;
    endtask

    initial begin
        bit got;
        bus.note_in_valid = 0; bus.note_in = '0; bus.note_in_duration = '0;
        #2;
        chk("rst_ready", 64'(bus.note_in_ready), 0);
        chk("rst_valid", 64'(valid), 0);
        chk("rst_beat", 64'(current_beat), 0);
        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1;
        chk("ready_after_rst", 64'(bus.note_in_ready), 1);

        // basic insert and publish
        play = 1;
        repeat (10) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 5, 24, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("basic_slot0", 64'(notes[0]), 64'(ent(5, 10, 24)));
        chk("basic_valid", 64'(valid), 1);
        chk("basic_slot1", 64'(notes[1]), 0);

        // beat_tick with insert uses pre-increment position
        step(1, 0, 1, 7, 30, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("tick_ins_slot1", 64'(notes[1]), 64'(ent(7, 10, 30)));
        chk("tick_ins_beat", 64'(current_beat), 11);

        // pause and done
        play = 0;
        repeat (5) step(1, 0, 0, 0, 0, 0);
        chk("pause_beat", 64'(current_beat), 11);
        play = 1; song_done = 1;
        repeat (5) step(1, 0, 0, 0, 0, 0);
        chk("done_beat", 64'(current_beat), 11);
        step(0, 0, 1, 8, 3, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("done_insert", 64'(notes[2]), 64'(ent(8, 11, 3)));
        song_done = 0;

        // zero duration, then full
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 3, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("zero_dur_slot0", 64'(notes[0]), 0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, i + 1, i + 1, 0);
        chk("full_ready", 64'(bus.note_in_ready), 0);
        step(0, 1, 0, 0, 0, 0);
        chk("full_slot15", 64'(notes[15]), 64'(ent(16, 0, 16)));
        bus.note_in_valid = 1; bus.note_in = 6'd9;
        bus.note_in_duration = 16'd50; beat_tick = 1;
        got = 0;
        for (int k = 0; k < 400 && !got; k++) begin
            got = bus.note_in_ready;
            @(posedge clk); #1;
        end
        bus.note_in_valid = 0; beat_tick = 0;
        chk("full_release", 64'(got), 1);
        step(0, 1, 0, 0, 0, 0);
        chk("held_insert", 64'(notes[0]), 64'(ent(9, 194, 50)));

        // eviction boundary plus same-cycle evict/insert
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 1, 8, 0);
        step(0, 0, 1, 2, 100, 0);
        repeat (199) step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("evict_199_slot0", 64'(notes[0]), 64'(ent(1, 0, 8)));
        chk("evict_199_beat", 64'(current_beat), 199);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 3, 5, 0);
        step(0, 1, 1, 4, 5, 0);
        chk("evict_200_slot0", 64'(notes[0]), 0);
        chk("same_cycle_slot2", 64'(notes[2]), 64'(ent(3, 200, 5)));
        step(0, 1, 0, 0, 0, 0);
        chk("reuse_slot0", 64'(notes[0]), 64'(ent(4, 200, 5)));
        chk("keep_slot1", 64'(notes[1]), 64'(ent(2, 0, 100)));

        // reset_player dominates insert and frame_start
        step(1, 1, 1, 5, 5, 1);
        chk("rp_valid", 64'(valid), 0);
        chk("rp_beat", 64'(current_beat), 0);
        step(0, 1, 0, 0, 0, 0);
        chk("rp_insert_lost", 64'(notes[0]), 0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            play = ($urandom % 16) != 0;
            if ($urandom % 200 == 0) song_done = ~song_done;
            step($urandom % 2, $urandom % 8 == 0, $urandom % 2,
                 int'($urandom % 64),
                 ($urandom % 10 == 0) ? 0 : int'($urandom_range(1, 60)),
                 $urandom % 500 == 0);
        end

        // asynchronous reset mid-cycle
        step(0, 1, 0, 0, 0, 0);
        @(posedge clk); #3; rst = 0; #1;
        chk("arst_valid", 64'(valid), 0);
        chk("arst_beat", 64'(current_beat), 0);
        chk("arst_ready", 64'(bus.note_in_ready), 0);
        for (int i = 0; i < 16; i++)
            chk($sformatf("arst_notes[%0d]", i), 64'(notes[i]), 0);
        @(posedge clk); #1; rst = 1;
        repeat (3) step(1, 1, 1, 2, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
